// File: rtl/i2c_target_pkg.sv
// Shared constants for the I2C target: one-hot FSM states and byte/bit geometry.
package i2c_target_pkg;

   // One-hot state encoding, one bit per state
   typedef enum logic [7:0] {
      IDLE     = 8'b0000_0001,
      ADDR     = 8'b0000_0010,
      ADDR_ACK = 8'b0000_0100,
      WR_BYTE  = 8'b0000_1000,
      WR_ACK   = 8'b0001_0000,
      RD_BYTE  = 8'b0010_0000,
      RD_ACK   = 8'b0100_0000,
      IGNORE   = 8'b1000_0000
   } state_t;

   localparam int         BYTE_BITS = 8;
   localparam logic [2:0] LAST_BIT  = 3'(BYTE_BITS - 1);  // bit counter value on the 8th bit
   localparam int         RW_IDX    = 0;                  // R/W flag position in the address byte

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus stability filter for one raw bus line, with registered edge strobes.
// Fixed latency: 2 sync stages + FILT_LEN stable samples.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int            CW   = $clog2(FILT_LEN + 1);
   localparam logic [CW-1:0] CMAX = CW'(FILT_LEN - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Two-stage synchroniser; idle bus level is high
   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], raw};
   end

   // Accept a new level only after FILT_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= 1'b1;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CMAX) begin
            level <= sync[1];
            cnt   <= '0;
            rise  <= sync[1];
            fall  <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint, 7-bit address, byte handshake to host logic, no clock stretching.
module i2c_target
   import i2c_target_pkg::*;
#(
   parameter int FILT_LEN = 3,
   parameter int SDA_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclIn,
   input  logic       sdaIn,
   output logic       sdaOut,
   input  logic [6:0] addr,
   output logic       busy,
   output logic       startDet,
   output logic       stopDet,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       rxFirst,
   output logic       txReq,
   input  logic [7:0] txData
);

   localparam int HW = $clog2(SDA_HOLD + 1);

   logic          scl, scl_rise, scl_fall;
   logic          sda, sda_rise, sda_fall;
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    sh, tx_sh, rx_next;
   logic          rw, ack_ph, first, tx_load, drive_val, addr_hit, start_c, stop_c;
   logic [HW-1:0] hold_cnt;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
      .clk(clk), .rst(rst), .raw(sclIn), .level(scl), .rise(scl_rise), .fall(scl_fall));
   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
      .clk(clk), .rst(rst), .raw(sdaIn), .level(sda), .rise(sda_rise), .fall(sda_fall));

   assign start_c  = sda_fall & scl;
   assign stop_c   = sda_rise & scl;
   assign rx_next  = {sh[6:0], sda};
   // general call (all-zero address) is never acknowledged
   assign addr_hit = (rx_next[7:1] == addr) && (rx_next[7:1] != 7'd0);

   // Level SDA should take once the hold time after an SCL fall expires
   always_comb begin
      drive_val = 1'b1;
      case (state)
         ADDR_ACK, WR_ACK: drive_val = ~ack_ph;
         RD_BYTE:          drive_val = tx_sh[~bit_cnt];
         default:          drive_val = 1'b1;
      endcase
   end

   // Protocol FSM; START/STOP override every state and any coincident data edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         sh       <= '0;
         tx_sh    <= '0;
         rw       <= 1'b0;
         ack_ph   <= 1'b0;
         first    <= 1'b0;
         tx_load  <= 1'b0;
         hold_cnt <= '0;
         sdaOut   <= 1'b1;
         busy     <= 1'b0;
         startDet <= 1'b0;
         stopDet  <= 1'b0;
         rxData   <= '0;
         rxValid  <= 1'b0;
         rxFirst  <= 1'b0;
         txReq    <= 1'b0;
      end else begin
         startDet <= 1'b0;
         stopDet  <= 1'b0;
         rxValid  <= 1'b0;
         txReq    <= 1'b0;
         // host answers txReq one cycle later
         tx_load  <= txReq;
         if (tx_load) tx_sh <= txData;
         if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
         if (hold_cnt == HW'(1)) sdaOut <= drive_val;

         if (start_c) begin
            state    <= ADDR;
            bit_cnt  <= '0;
            ack_ph   <= 1'b0;
            busy     <= 1'b0;
            startDet <= 1'b1;
            sdaOut   <= 1'b1;
            hold_cnt <= '0;
         end else if (stop_c) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            ack_ph   <= 1'b0;
            busy     <= 1'b0;
            stopDet  <= 1'b1;
            sdaOut   <= 1'b1;
            hold_cnt <= '0;
         end else begin
            if (scl_fall) hold_cnt <= HW'(SDA_HOLD);
            case (state)
               ADDR: if (scl_rise) begin
                  sh      <= rx_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     if (addr_hit) begin
                        state  <= ADDR_ACK;
                        rw     <= rx_next[RW_IDX];
                        busy   <= 1'b1;
                        first  <= 1'b1;
                        ack_ph <= 1'b0;
                     end else begin
                        state  <= IGNORE;
                     end
                  end
               end
               // first fall starts the ACK drive, second fall ends the ACK clock
               ADDR_ACK: if (scl_fall) begin
                  if (!ack_ph) begin
                     ack_ph <= 1'b1;
                     if (rw) txReq <= 1'b1;
                  end else begin
                     ack_ph  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= rw ? RD_BYTE : WR_BYTE;
                  end
               end
               WR_BYTE: if (scl_rise) begin
                  sh      <= rx_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     rxData  <= rx_next;
                     rxValid <= 1'b1;
                     rxFirst <= first;
                     first   <= 1'b0;
                     ack_ph  <= 1'b0;
                     state   <= WR_ACK;
                  end
               end
               WR_ACK: if (scl_fall) begin
                  if (!ack_ph) begin
                     ack_ph <= 1'b1;
                  end else begin
                     ack_ph  <= 1'b0;
                     bit_cnt <= '0;
                     state   <= WR_BYTE;
                  end
               end
               RD_BYTE: if (scl_fall) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
                     state   <= RD_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               // master NACK ends the read; ACK fetches the next byte
               RD_ACK: begin
                  if (scl_rise && sda) begin
                     busy  <= 1'b0;
                     state <= IGNORE;
                  end else if (scl_fall) begin
                     txReq   <= 1'b1;
                     bit_cnt <= '0;
                     state   <= RD_BYTE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: open-drain bus model with pull-up, bit-banged 100 kHz master.
module tb_i2c_target;

   localparam int Q = 62;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m, sda_m, sda_bus;
   logic       sdaOut, busy, startDet, stopDet, rxValid, rxFirst, txReq;
   logic [6:0] addr;
   logic [7:0] rxData;
   logic [7:0] txData = 8'h00;

   assign sda_bus = sda_m & sdaOut;

   always #20 clk = ~clk;

   i2c_target dut (
      .clk(clk), .rst(rst), .sclIn(scl_m), .sdaIn(sda_bus), .sdaOut(sdaOut),
      .addr(addr), .busy(busy), .startDet(startDet), .stopDet(stopDet),
      .rxData(rxData), .rxValid(rxValid), .rxFirst(rxFirst),
      .txReq(txReq), .txData(txData));

   int n_chk = 0, n_err = 0;
   int c_rx = 0, c_tx = 0, c_start = 0, c_stop = 0, c_drive = 0;
   logic [8:0] exp_rx[$];
   logic [7:0] exp_rd[$];
   logic [7:0] tx_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: scoreboard for rxValid, host model for txReq, event counters
   always @(negedge clk) begin
      if (!rst) begin
         if (rxValid) begin
            logic [8:0] e;
            c_rx++;
            chk("rx_pending", 32'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) begin
               e = exp_rx.pop_front();
               chk("rx_data", rxData, e[7:0]);
               chk("rx_first", rxFirst, e[8]);
            end
         end
         if (txReq) begin
            c_tx++;
            if (tx_q.size() > 0) txData = tx_q.pop_front();
         end
         if (startDet) c_start++;
         if (stopDet) c_stop++;
         if (sdaOut === 1'b0) c_drive++;
      end
   end

   task automatic wt(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      if (!scl_m) begin sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q); end
      sda_m = 1'b0; wt(Q); scl_m = 1'b0; wt(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b1; wt(2*Q);
   endtask

   // One SCL clock; optional SCL low glitch of glen clk in the high phase
   task automatic bit_io(input logic b, input int glen, output logic r);
      sda_m = b; wt(Q); scl_m = 1'b1; wt(Q);
      if (glen > 0) begin scl_m = 1'b0; wt(glen); scl_m = 1'b1; wt(Q); end
      r = sda_bus; wt(Q); scl_m = 1'b0; wt(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input int glen, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_io(b[i], (i == 7) ? glen : 0, r);
      bit_io(1'b1, 0, ack);
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic r;
      for (int i = 7; i >= 0; i--) begin bit_io(1'b1, 0, r); d[i] = r; end
      bit_io(mack, 0, r);
   endtask

   initial begin
      #(100000 * 40);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      logic [7:0] d;
      int r0, t0, s0, p0, v0;
      rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; addr = 7'h50;
      wt(3);
      chk("rst_sda", sdaOut, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rxdata", rxData, 0);
      chk("rst_rxfirst", rxFirst, 0);
      chk("rst_rxvalid", rxValid, 0);
      chk("rst_txreq", txReq, 0);
      chk("rst_start", startDet, 0);
      chk("rst_stop", stopDet, 0);
      rst = 1'b0;
      wt(10);

      // write two bytes
      r0 = c_rx; s0 = c_start; p0 = c_stop;
      i2c_start();
      wr_byte(8'hA0, 0, a); chk("wr_addr_ack", a, 0); chk("wr_busy", busy, 1);
      exp_rx.push_back({1'b1, 8'h12}); wr_byte(8'h12, 0, a); chk("wr_b0_ack", a, 0);
      exp_rx.push_back({1'b0, 8'hAB}); wr_byte(8'hAB, 0, a); chk("wr_b1_ack", a, 0);
      i2c_stop();
      chk("wr_rx_cnt", c_rx - r0, 2);
      chk("wr_start_cnt", c_start - s0, 1);
      chk("wr_stop_cnt", c_stop - p0, 1);
      chk("wr_busy_end", busy, 0);

      // read two bytes, ACK then NACK
      t0 = c_tx;
      tx_q.push_back(8'h3C); tx_q.push_back(8'hC3);
      exp_rd.push_back(8'h3C); exp_rd.push_back(8'hC3);
      i2c_start();
      wr_byte(8'hA1, 0, a); chk("rd_addr_ack", a, 0);
      rd_byte(1'b0, d); chk("rd_b0", d, exp_rd.pop_front());
      rd_byte(1'b1, d); chk("rd_b1", d, exp_rd.pop_front());
      chk("rd_busy_nack", busy, 0);
      i2c_stop();
      chk("rd_txreq_cnt", c_tx - t0, 2);

      // address mismatch: SDA never driven
      r0 = c_rx; t0 = c_tx; v0 = c_drive;
      i2c_start();
      wr_byte(8'hA4, 0, a); chk("mm_nack", a, 1);
      wr_byte(8'h11, 0, a); wr_byte(8'h22, 0, a);
      i2c_stop();
      chk("mm_drive", c_drive - v0, 0);
      chk("mm_rx_cnt", c_rx - r0, 0);
      chk("mm_txreq_cnt", c_tx - t0, 0);

      // repeated START: write pointer then read one byte
      s0 = c_start; p0 = c_stop; t0 = c_tx;
      tx_q.push_back(8'h5E); exp_rd.push_back(8'h5E);
      i2c_start();
      wr_byte(8'hA0, 0, a); chk("sr_waddr_ack", a, 0);
      exp_rx.push_back({1'b1, 8'h07}); wr_byte(8'h07, 0, a); chk("sr_ptr_ack", a, 0);
      i2c_start();
      wr_byte(8'hA1, 0, a); chk("sr_raddr_ack", a, 0);
      rd_byte(1'b1, d); chk("sr_rd", d, exp_rd.pop_front());
      chk("sr_no_stop", c_stop - p0, 0);
      i2c_stop();
      chk("sr_start_cnt", c_start - s0, 2);
      chk("sr_txreq_cnt", c_tx - t0, 1);
      chk("sr_stop_cnt", c_stop - p0, 1);

      // SCL glitches: 2 clk ignored, FILT_LEN clk counted as an extra clock
      r0 = c_rx;
      i2c_start();
      wr_byte(8'hA0, 0, a); chk("gl_addr_ack", a, 0);
      exp_rx.push_back({1'b1, 8'h96}); wr_byte(8'h96, 2, a); chk("gl_short_ack", a, 0);
      exp_rx.push_back({1'b0, 8'h2D}); wr_byte(8'h5A, 3, a);
      i2c_stop();
      chk("gl_rx_cnt", c_rx - r0, 2);

      // reset while the target drives a 0 data bit
      tx_q.push_back(8'h00);
      i2c_start();
      wr_byte(8'hA1, 0, a); chk("rs_addr_ack", a, 0);
      chk("rs_pre_drive", sdaOut, 0);
      chk("rs_pre_busy", busy, 1);
      rst = 1'b1; wt(1);
      chk("rs_sda", sdaOut, 1);
      chk("rs_busy", busy, 0);
      rst = 1'b0;
      i2c_stop();
      r0 = c_rx;
      i2c_start();
      wr_byte(8'hA0, 0, a); chk("rs_post_ack", a, 0);
      exp_rx.push_back({1'b1, 8'h33}); wr_byte(8'h33, 0, a); chk("rs_post_b_ack", a, 0);
      i2c_stop();
      chk("rs_post_rx_cnt", c_rx - r0, 1);

      wt(20);
      chk("sb_empty", exp_rx.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
